// File: rtl/ika9958_extclk_sync.sv
// External DLCLK_n receiver: synchronises the master VDP dot clock, locks a local 4-phase counter to it
// and regenerates phiH/phiL enables. Define IKA9958_EXTCLK_HOLDOVER_EN to add the HOLD (holdover) state.
module ika9958_extclk_sync #(
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 2
) (
  input  logic       i_PHIA,
  input  logic       i_RST,
  input  logic       i_PHIA_NCEN,
  input  logic       i_EXTSYNC_EN,
  input  logic       i_DLCLK_n,
  output logic       o_PHIH_PCEN,
  output logic       o_PHIH_NCEN,
  output logic       o_PHIL_PCEN,
  output logic       o_PHIL_NCEN,
  output logic [1:0] o_PHASE,
  output logic       o_LOCKED,
  output logic       o_LOSS
);

  if (LOCK_CNT < 1 || LOCK_CNT > 15 || MISS_MAX < 1 || MISS_MAX > 7) begin : g_bad_param
    $error("ika9958_extclk_sync: LOCK_CNT must be 1..15 and MISS_MAX 1..7");
  end

  typedef enum logic [1:0] {ST_ACQ, ST_LOCK, ST_HOLD} state_t;

  localparam logic [3:0] LOCK_CNT_V = 4'(LOCK_CNT);

  state_t     state;
  logic       s1, s2, s3;
  logic [1:0] ph;
  logic [3:0] good_cnt;
  logic       loss;
`ifdef IKA9958_EXTCLK_HOLDOVER_EN
  localparam logic [2:0] MISS_MAX_V = 3'(MISS_MAX);
  logic [2:0] miss_cnt;
`endif

  logic dl_edge, good, bad, active;

  // Falling edge of DLCLK_n marks the master's phiL rise; classification uses ph before realignment.
  assign dl_edge = s3 & ~s2;
  assign good    = dl_edge & (ph == 2'd3);
  assign bad     = dl_edge ^ (ph == 2'd3);

  // NOTE: every state bit, including the synchroniser, is assigned with <= so all flops sample the
  // same pre-edge values; a blocking = here would collapse the s1->s2->s3 chain into one stage.
  always_ff @(posedge i_PHIA or posedge i_RST) begin
    if (i_RST) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      s3       <= 1'b1;
      ph       <= 2'd0;
      state    <= ST_ACQ;
      good_cnt <= 4'd0;
      loss     <= 1'b0;
`ifdef IKA9958_EXTCLK_HOLDOVER_EN
      miss_cnt <= 3'd0;
`endif
    end else if (i_PHIA_NCEN) begin
      s1   <= i_DLCLK_n;
      s2   <= s1;
      s3   <= s2;
      ph   <= dl_edge ? 2'd0 : ph + 2'd1;
      loss <= 1'b0;
      if (!i_EXTSYNC_EN) begin
        // Deselecting the external clock is deliberate, so it never reports loss.
        state    <= ST_ACQ;
        good_cnt <= 4'd0;
`ifdef IKA9958_EXTCLK_HOLDOVER_EN
        miss_cnt <= 3'd0;
`endif
      end else begin
        case (state)
          ST_ACQ: begin
            if (good) begin
              if (good_cnt + 4'd1 == LOCK_CNT_V) begin
                state    <= ST_LOCK;
                good_cnt <= 4'd0;
              end else begin
                good_cnt <= good_cnt + 4'd1;
              end
            end else if (bad) begin
              good_cnt <= 4'd0;
            end
          end
          ST_LOCK: begin
            if (bad) begin
`ifdef IKA9958_EXTCLK_HOLDOVER_EN
              state    <= ST_HOLD;
              miss_cnt <= 3'd1;
`else
              state <= ST_ACQ;
              loss  <= 1'b1;
`endif
            end
          end
`ifdef IKA9958_EXTCLK_HOLDOVER_EN
          ST_HOLD: begin
            if (good) begin
              state    <= ST_LOCK;
              miss_cnt <= 3'd0;
            end else if (bad) begin
              if (miss_cnt + 3'd1 == MISS_MAX_V) begin
                state    <= ST_ACQ;
                miss_cnt <= 3'd0;
                loss     <= 1'b1;
              end else begin
                miss_cnt <= miss_cnt + 3'd1;
              end
            end
          end
`endif
          default: state <= ST_ACQ;
        endcase
      end
    end
  end

  // NOTE: the enables are pure continuous assigns of registered state; no always_comb is
  // needed, so there is no path that could leave an output unassigned and infer a latch.
  assign active      = i_PHIA_NCEN & ((state == ST_LOCK) | (state == ST_HOLD));
  assign o_PHIL_PCEN = active & (ph == 2'd0);
  assign o_PHIL_NCEN = active & (ph == 2'd2);
  assign o_PHIH_PCEN = active & ~ph[0];
  assign o_PHIH_NCEN = active &  ph[0];
  assign o_PHASE     = ph;
  assign o_LOCKED    = (state == ST_LOCK);
  assign o_LOSS      = loss;

endmodule
